// File: rtl/multicycle_controller_pkg.sv
// multicycle_controller_pkg: shared encodings for the multicycle controller
// Holds the FSM state encoding, RV32 opcodes, imm_*_type codes, result/ALU source
// selects, branch funct3 codes and the DECODE dispatch function.
// ILLEGAL_TRAP_EN adds the ILLEGAL state and routes unknown opcodes to it.
package multicycle_controller_pkg;
   typedef enum logic [3:0] {
      FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I,
      ALU_WB, BRANCH, JAL, JALR, LUI
`ifdef ILLEGAL_TRAP_EN
      , ILLEGAL
`endif
   } state_t;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [2:0] imm_I_type = 3'd0;
   localparam logic [2:0] imm_S_type = 3'd1;
   localparam logic [2:0] imm_B_type = 3'd2;
   localparam logic [2:0] imm_J_type = 3'd3;
   localparam logic [2:0] imm_U_type = 3'd4;
   localparam logic [1:0] RES_ALU = 2'd0;
   localparam logic [1:0] RES_MEM = 2'd1;
   localparam logic [1:0] RES_IMM = 2'd2;
   localparam logic [1:0] SRCA_PC    = 2'd0;
   localparam logic [1:0] SRCA_OLDPC = 2'd1;
   localparam logic [1:0] SRCA_RS1   = 2'd2;
   localparam logic [1:0] SRCB_RS2  = 2'd0;
   localparam logic [1:0] SRCB_IMM  = 2'd1;
   localparam logic [1:0] SRCB_FOUR = 2'd2;
   localparam logic [1:0] ALUOP_ADD   = 2'd0;
   localparam logic [1:0] ALUOP_SUB   = 2'd1;
   localparam logic [1:0] ALUOP_FUNCT = 2'd2;
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;
   localparam logic [2:0] F3_BLT = 3'b100;
   localparam logic [2:0] F3_BGE = 3'b101;
   function automatic state_t decode_op(input logic [6:0] op);
      case (op)
         OP_LOAD, OP_STORE: return MEM_ADR;
         OP_R:              return EXEC_R;
         OP_I:              return EXEC_I;
         OP_BRANCH:         return BRANCH;
         OP_JAL:            return JAL;
         OP_JALR:           return JALR;
         OP_LUI:            return LUI;
`ifdef ILLEGAL_TRAP_EN
         default:           return ILLEGAL;
`else
         default:           return FETCH;
`endif
      endcase
   endfunction
endpackage

// File: rtl/multicycle_controller_branch_cond.sv
// multicycle_controller_branch_cond: decides whether a conditional branch is taken
// Ports: i_funct3 branch sub-function, i_zero ALU zero flag, i_lt ALU signed
// less-than flag, o_take branch taken (0 for unsupported funct3).
module multicycle_controller_branch_cond
   import multicycle_controller_pkg::*;
(
   input  logic [2:0] i_funct3,
   input  logic       i_zero,
   input  logic       i_lt,
   output logic       o_take
);
   assign o_take = (i_funct3 == F3_BEQ) ?  i_zero :
                   (i_funct3 == F3_BNE) ? !i_zero :
                   (i_funct3 == F3_BLT) ?  i_lt   :
                   (i_funct3 == F3_BGE) ? !i_lt   : 1'b0;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a multicycle RV32 datapath
// Inputs: clk, rst (async active-low), op, funct3, alu_zero, alu_lt, mem_ready.
// Outputs: pc_write, ir_write, adr_src, mem_write, reg_write, alu_src_a/b, alu_op,
// result_src, imm_src, illegal. Define ILLEGAL_TRAP_EN to trap unknown opcodes.
module multicycle_controller
   import multicycle_controller_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       alu_zero,
   input  logic       alu_lt,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       ir_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] result_src,
   output logic [2:0] imm_src,
   output logic       illegal
);
   state_t r_state;
   logic   w_take;
   multicycle_controller_branch_cond u_branch_cond (
      .i_funct3 (funct3),
      .i_zero   (alu_zero),
      .i_lt     (alu_lt),
      .o_take   (w_take)
   );
   always_ff @(posedge clk or negedge rst)
      if (!rst) r_state <= FETCH;
      else
         case (r_state)
            FETCH:                     if (mem_ready) r_state <= DECODE;
            DECODE:                    r_state <= decode_op(op);
            MEM_ADR:                   r_state <= (op == OP_STORE) ? MEM_WR : MEM_RD;
            MEM_RD:                    if (mem_ready) r_state <= MEM_WB;
            MEM_WR:                    if (mem_ready) r_state <= FETCH;
            EXEC_R, EXEC_I, JAL, JALR: r_state <= ALU_WB;
`ifdef ILLEGAL_TRAP_EN
            ILLEGAL:                   r_state <= ILLEGAL;
`endif
            default:                   r_state <= FETCH;
         endcase
   // Gating with rst makes every output drop the instant reset asserts,
   // including a store in flight in MEM_WR.
   always_comb begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      alu_op     = ALUOP_ADD;
      result_src = RES_ALU;
      imm_src    = imm_I_type;
      illegal    = 1'b0;
      if (rst)
         case (r_state)
            FETCH: begin
               ir_write  = 1'b1;
               pc_write  = mem_ready;
               alu_src_b = SRCB_FOUR;
            end
            DECODE: begin
               alu_src_a = SRCA_OLDPC;
               alu_src_b = SRCB_IMM;
               imm_src   = imm_B_type;
            end
            MEM_ADR: begin
               alu_src_a = SRCA_RS1;
               alu_src_b = SRCB_IMM;
               imm_src   = (op == OP_STORE) ? imm_S_type : imm_I_type;
            end
            MEM_RD:  adr_src = 1'b1;
            MEM_WB: begin
               reg_write  = 1'b1;
               result_src = RES_MEM;
            end
            MEM_WR: begin
               adr_src   = 1'b1;
               mem_write = 1'b1;
            end
            EXEC_R: begin
               alu_src_a = SRCA_RS1;
               alu_op    = ALUOP_FUNCT;
            end
            EXEC_I: begin
               alu_src_a = SRCA_RS1;
               alu_src_b = SRCB_IMM;
               alu_op    = ALUOP_FUNCT;
            end
            ALU_WB:  reg_write = 1'b1;
            BRANCH: begin
               alu_src_a = SRCA_RS1;
               alu_op    = ALUOP_SUB;
               imm_src   = imm_B_type;
               pc_write  = w_take;
            end
            JAL: begin
               alu_src_a = SRCA_OLDPC;
               alu_src_b = SRCB_FOUR;
               imm_src   = imm_J_type;
               pc_write  = 1'b1;
            end
            JALR: begin
               alu_src_a = SRCA_OLDPC;
               alu_src_b = SRCB_FOUR;
               pc_write  = 1'b1;
            end
            LUI: begin
               reg_write  = 1'b1;
               result_src = RES_IMM;
               imm_src    = imm_U_type;
            end
`ifdef ILLEGAL_TRAP_EN
            ILLEGAL: illegal = 1'b1;
`endif
            default: ;
         endcase
   end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed self-checking bench for multicycle_controller
module tb_multicycle_controller;
   import multicycle_controller_pkg::*;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [6:0] op = 7'b0;
   logic [2:0] funct3 = 3'b0;
   logic       alu_zero = 1'b0;
   logic       alu_lt = 1'b0;
   logic       mem_ready = 1'b0;
   logic       pc_write, ir_write, adr_src, mem_write, reg_write, illegal;
   logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
   logic [2:0] imm_src;
   logic [3:0] w_en;
   int         n_cmp = 0;
   int         n_err = 0;
   always #5 clk = ~clk;
   assign w_en = {pc_write, ir_write, mem_write, reg_write};
   multicycle_controller dut (
      .clk        (clk),
      .rst        (rst),
      .op         (op),
      .funct3     (funct3),
      .alu_zero   (alu_zero),
      .alu_lt     (alu_lt),
      .mem_ready  (mem_ready),
      .pc_write   (pc_write),
      .ir_write   (ir_write),
      .adr_src    (adr_src),
      .mem_write  (mem_write),
      .reg_write  (reg_write),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .result_src (result_src),
      .imm_src    (imm_src),
      .illegal    (illegal)
   );
   task automatic test_reset();
      rst = 1'b0;
      mem_ready = 1'b1;
      op = 7'b0110011;
      #1;
      n_cmp++;
      if ({pc_write, ir_write, adr_src, mem_write, reg_write, illegal} !== 6'b0) begin
         n_err++;
         $display("FAIL reset_enables: got %b want 000000", {pc_write, ir_write, adr_src, mem_write, reg_write, illegal});
      end
      n_cmp++;
      if ({alu_src_a, alu_src_b, alu_op, result_src, imm_src} !== 11'b0) begin
         n_err++;
         $display("FAIL reset_selects: got %b want 0", {alu_src_a, alu_src_b, alu_op, result_src, imm_src});
      end
      @(negedge clk);
      rst = 1'b1;
      mem_ready = 1'b0;
      #1;
      n_cmp++;
      if ({ir_write, pc_write} !== 2'b10) begin
         n_err++;
         $display("FAIL reset_release_fetch: got ir/pc %b want 10", {ir_write, pc_write});
      end
   endtask
   task automatic test_add();
      logic [3:0] en [0:3];
      en = '{4'b1100, 4'b0000, 4'b0000, 4'b0001};
      op = 7'b0110011;
      for (int i = 0; i < 4; i++) begin
         mem_ready = 1'b1;
         #1;
         n_cmp++;
         if (w_en !== en[i]) begin
            n_err++;
            $display("FAIL add_cycle%0d: got en %b want %b", i, w_en, en[i]);
         end
         if (i == 3) begin
            n_cmp++;
            if (result_src !== 2'd0) begin
               n_err++;
               $display("FAIL add_result_src: got %0d want 0", result_src);
            end
         end
         @(negedge clk);
      end
      mem_ready = 1'b0;
      #1;
      n_cmp++;
      if ({ir_write, pc_write} !== 2'b10) begin
         n_err++;
         $display("FAIL add_end_fetch: got ir/pc %b want 10", {ir_write, pc_write});
      end
   endtask
   task automatic test_lw();
      logic [3:0] en [0:6];
      logic       mr [0:6];
      logic       adr [0:6];
      int         n_rw = 0;
      en  = '{4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
      mr  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      adr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      op = 7'b0000011;
      for (int i = 0; i < 7; i++) begin
         mem_ready = mr[i];
         #1;
         n_rw += int'(reg_write);
         n_cmp++;
         if ({w_en, adr_src} !== {en[i], adr[i]}) begin
            n_err++;
            $display("FAIL lw_cycle%0d: got en/adr %b want %b", i, {w_en, adr_src}, {en[i], adr[i]});
         end
         if (i == 2) begin
            n_cmp++;
            if (imm_src !== imm_I_type) begin
               n_err++;
               $display("FAIL lw_imm_src: got %0d want %0d", imm_src, imm_I_type);
            end
         end
         if (i == 6) begin
            n_cmp++;
            if (result_src !== 2'd1) begin
               n_err++;
               $display("FAIL lw_result_src: got %0d want 1", result_src);
            end
         end
         @(negedge clk);
      end
      n_cmp++;
      if (n_rw != 1) begin
         n_err++;
         $display("FAIL lw_reg_write_count: got %0d want 1", n_rw);
      end
      mem_ready = 1'b0;
      #1;
      n_cmp++;
      if ({ir_write, pc_write} !== 2'b10) begin
         n_err++;
         $display("FAIL lw_end_fetch: got ir/pc %b want 10", {ir_write, pc_write});
      end
   endtask
   task automatic test_sw();
      logic [3:0] en [0:4];
      logic       mr [0:4];
      en = '{4'b1100, 4'b0000, 4'b0000, 4'b0010, 4'b0010};
      mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      op = 7'b0100011;
      for (int i = 0; i < 5; i++) begin
         mem_ready = mr[i];
         #1;
         n_cmp++;
         if (w_en !== en[i]) begin
            n_err++;
            $display("FAIL sw_cycle%0d: got en %b want %b", i, w_en, en[i]);
         end
         if (i == 2) begin
            n_cmp++;
            if (imm_src !== imm_S_type) begin
               n_err++;
               $display("FAIL sw_imm_src: got %0d want %0d", imm_src, imm_S_type);
            end
         end
         if (i >= 3) begin
            n_cmp++;
            if (adr_src !== 1'b1) begin
               n_err++;
               $display("FAIL sw_adr_src%0d: got %b want 1", i, adr_src);
            end
         end
         @(negedge clk);
      end
      mem_ready = 1'b0;
      #1;
      n_cmp++;
      if ({ir_write, pc_write} !== 2'b10) begin
         n_err++;
         $display("FAIL sw_end_fetch: got ir/pc %b want 10", {ir_write, pc_write});
      end
   endtask
   task automatic test_branch();
      logic [5:0] tbl [0:7];
      tbl = '{{3'b000, 1'b1, 1'b0, 1'b1}, {3'b000, 1'b0, 1'b0, 1'b0},
              {3'b001, 1'b0, 1'b0, 1'b1}, {3'b001, 1'b1, 1'b0, 1'b0},
              {3'b100, 1'b0, 1'b1, 1'b1}, {3'b101, 1'b0, 1'b1, 1'b0},
              {3'b101, 1'b0, 1'b0, 1'b1}, {3'b010, 1'b1, 1'b1, 1'b0}};
      op = 7'b1100011;
      for (int k = 0; k < 8; k++) begin
         funct3 = tbl[k][5:3];
         mem_ready = 1'b1;
         #1;
         n_cmp++;
         if (w_en !== 4'b1100) begin
            n_err++;
            $display("FAIL br%0d_fetch: got en %b want 1100", k, w_en);
         end
         @(negedge clk);
         #1;
         n_cmp++;
         if ({w_en, imm_src} !== {4'b0000, imm_B_type}) begin
            n_err++;
            $display("FAIL br%0d_decode: got en/imm %b want %b", k, {w_en, imm_src}, {4'b0000, imm_B_type});
         end
         @(negedge clk);
         alu_zero = tbl[k][2];
         alu_lt = tbl[k][1];
         #1;
         n_cmp++;
         if ({w_en, imm_src} !== {tbl[k][0], 3'b000, imm_B_type}) begin
            n_err++;
            $display("FAIL br%0d_branch: got en/imm %b want %b", k, {w_en, imm_src}, {tbl[k][0], 3'b000, imm_B_type});
         end
         @(negedge clk);
         alu_zero = 1'b0;
         alu_lt = 1'b0;
         mem_ready = 1'b0;
         #1;
         n_cmp++;
         if ({ir_write, pc_write} !== 2'b10) begin
            n_err++;
            $display("FAIL br%0d_end_fetch: got ir/pc %b want 10", k, {ir_write, pc_write});
         end
      end
      funct3 = 3'b0;
   endtask
   task automatic test_jump();
      logic [3:0] en [0:3];
      en = '{4'b1100, 4'b0000, 4'b1000, 4'b0001};
      for (int j = 0; j < 2; j++) begin
         op = (j == 0) ? 7'b1101111 : 7'b1100111;
         for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1;
            #1;
            n_cmp++;
            if (w_en !== en[i]) begin
               n_err++;
               $display("FAIL jump%0d_cycle%0d: got en %b want %b", j, i, w_en, en[i]);
            end
            if (i == 2) begin
               n_cmp++;
               if (imm_src !== ((j == 0) ? imm_J_type : imm_I_type)) begin
                  n_err++;
                  $display("FAIL jump%0d_imm_src: got %0d", j, imm_src);
               end
            end
            @(negedge clk);
         end
         mem_ready = 1'b0;
         #1;
         n_cmp++;
         if ({ir_write, pc_write} !== 2'b10) begin
            n_err++;
            $display("FAIL jump%0d_end_fetch: got ir/pc %b want 10", j, {ir_write, pc_write});
         end
      end
   endtask
   task automatic test_lui();
      logic [3:0] en [0:2];
      en = '{4'b1100, 4'b0000, 4'b0001};
      op = 7'b0110111;
      for (int i = 0; i < 3; i++) begin
         mem_ready = 1'b1;
         #1;
         n_cmp++;
         if (w_en !== en[i]) begin
            n_err++;
            $display("FAIL lui_cycle%0d: got en %b want %b", i, w_en, en[i]);
         end
         if (i == 2) begin
            n_cmp++;
            if ({result_src, imm_src} !== {2'd2, imm_U_type}) begin
               n_err++;
               $display("FAIL lui_selects: got res/imm %b want %b", {result_src, imm_src}, {2'd2, imm_U_type});
            end
         end
         @(negedge clk);
      end
      mem_ready = 1'b0;
      #1;
      n_cmp++;
      if ({ir_write, pc_write} !== 2'b10) begin
         n_err++;
         $display("FAIL lui_end_fetch: got ir/pc %b want 10", {ir_write, pc_write});
      end
   endtask
   task automatic test_reset_mid_wr();
      op = 7'b0100011;
      for (int i = 0; i < 3; i++) begin
         mem_ready = 1'b1;
         @(negedge clk);
      end
      mem_ready = 1'b0;
      #1;
      n_cmp++;
      if ({mem_write, adr_src} !== 2'b11) begin
         n_err++;
         $display("FAIL rstwr_in_mem_wr: got mw/adr %b want 11", {mem_write, adr_src});
      end
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({mem_write, adr_src} !== 2'b00) begin
         n_err++;
         $display("FAIL rstwr_async_drop: got mw/adr %b want 00", {mem_write, adr_src});
      end
      @(negedge clk);
      mem_ready = 1'b1;
      @(negedge clk);
      #1;
      n_cmp++;
      if (w_en !== 4'b0000) begin
         n_err++;
         $display("FAIL rstwr_held: got en %b want 0000", w_en);
      end
      rst = 1'b1;
      mem_ready = 1'b0;
      #1;
      n_cmp++;
      if (w_en !== 4'b0100) begin
         n_err++;
         $display("FAIL rstwr_release_fetch: got en %b want 0100", w_en);
      end
   endtask
   task automatic test_illegal();
      op = 7'b0000000;
      mem_ready = 1'b1;
      #1;
      n_cmp++;
      if (w_en !== 4'b1100) begin
         n_err++;
         $display("FAIL ill_fetch: got en %b want 1100", w_en);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if ({w_en, illegal} !== 5'b00000) begin
         n_err++;
         $display("FAIL ill_decode: got en/illegal %b want 00000", {w_en, illegal});
      end
      @(negedge clk);
`ifdef ILLEGAL_TRAP_EN
      for (int i = 0; i < 10; i++) begin
         #1;
         n_cmp++;
         if ({w_en, illegal} !== 5'b00001) begin
            n_err++;
            $display("FAIL ill_hold%0d: got en/illegal %b want 00001", i, {w_en, illegal});
         end
         @(negedge clk);
      end
      rst = 1'b0;
      #1;
      n_cmp++;
      if (illegal !== 1'b0) begin
         n_err++;
         $display("FAIL ill_reset_clear: got %b want 0", illegal);
      end
      @(negedge clk);
      rst = 1'b1;
`else
      mem_ready = 1'b0;
      #1;
      n_cmp++;
      if ({ir_write, pc_write, illegal} !== 3'b100) begin
         n_err++;
         $display("FAIL ill_back_to_fetch: got ir/pc/illegal %b want 100", {ir_write, pc_write, illegal});
      end
`endif
   endtask
   initial begin
      test_reset();
      test_add();
      test_lw();
      test_sw();
      test_branch();
      test_jump();
      test_lui();
      test_reset_mid_wr();
      test_illegal();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have no parameters; all encodings SHALL come from the shared constants file.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port op, input, 7 bits: instruction opcode field, taken from the instruction register.
REQ-005 The block SHALL have port funct3, input, 3 bits: branch/ALU sub-function.
REQ-006 The block SHALL have port alu_zero, input, 1 bit: ALU result equals zero.
REQ-007 The block SHALL have port alu_lt, input, 1 bit: signed less-than flag from the ALU.
REQ-008 The block SHALL have port mem_ready, input, 1 bit: the memory access completes this cycle.
REQ-009 The block SHALL have port pc_write, output, 1 bit: PC register load enable.
REQ-010 The block SHALL have port ir_write, output, 1 bit: instruction register load enable.
REQ-011 The block SHALL have ports adr_src, output, 1 bit (0=PC, 1=ALU result), and mem_write, output, 1 bit.
REQ-012 The block SHALL have port reg_write, output, 1 bit: register file write enable.
REQ-013 The block SHALL have ports alu_src_a and alu_src_b, output, 2 bits each, and alu_op, output, 2 bits.
REQ-014 The block SHALL have port result_src, output, 2 bits: 0=ALU register, 1=memory data, 2=immediate.
REQ-015 The block SHALL have port imm_src, output, 3 bits: select for the immediate extender, using the shared imm_I/S/B/J/U_type codes.
REQ-016 The block SHALL have port illegal, output, 1 bit: sticky illegal-opcode flag (see REQ-032).

Function
REQ-017 The block SHALL be a Moore FSM; all outputs except pc_write SHALL decode from the state register only.
REQ-018 States SHALL be FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, JALR, LUI, ILLEGAL.
REQ-019 FETCH SHALL hold with adr_src=0 until mem_ready=1; in that cycle, ir_write=1 and pc_write=1 (PC+4), and the next state SHALL be DECODE.
REQ-020 DECODE SHALL branch on op as follows: lw/sw->MEM_ADR, R->EXEC_R, I-ALU->EXEC_I, B->BRANCH, jal->JAL, jalr->JALR, lui->LUI; any other op->FETCH, or ILLEGAL when the macro is set.
REQ-021 MEM_ADR SHALL go to MEM_RD for lw and to MEM_WR for sw; MEM_RD SHALL hold until mem_ready, then go to MEM_WB; MEM_WB SHALL assert reg_write with result_src=1, then go to FETCH.
REQ-022 MEM_WR SHALL assert mem_write and adr_src=1 every cycle until mem_ready, then go to FETCH.
REQ-023 EXEC_R, EXEC_I, JAL and JALR SHALL go to ALU_WB; ALU_WB SHALL assert reg_write with result_src=0, then go to FETCH.
REQ-024 JAL and JALR SHALL assert pc_write unconditionally; BRANCH SHALL assert pc_write iff the condition holds, then go to FETCH.
REQ-025 Branch conditions SHALL be: beq alu_zero, bne !alu_zero, blt alu_lt, bge !alu_lt; any other funct3 SHALL leave pc_write=0.
REQ-026 LUI SHALL assert reg_write with result_src=2 and imm_src=U, then go to FETCH.
REQ-027 imm_src SHALL be I in MEM_ADR (lw), EXEC_I and JALR; S in MEM_ADR (sw); B in DECODE and BRANCH; J in JAL; and otherwise I.
REQ-028 Cycle counts at mem_ready=1 SHALL be: R/I-ALU 4, lw 5, sw 4, branch 3, jal/jalr 4, lui 3.

Reset
REQ-029 While rst=0, the state SHALL be FETCH and all enables SHALL be 0, taking effect immediately without waiting for a clock edge.
REQ-030 While rst=0, illegal SHALL be 0 and all selects SHALL be 0.
REQ-031 A reset asserted during MEM_WR SHALL drop mem_write within the same cycle, and no partial write enable SHALL persist.

Configuration
REQ-032 With macro ILLEGAL_TRAP_EN defined, an unknown op in DECODE SHALL enter ILLEGAL, set illegal=1, and hold there with all enables 0 until reset.
REQ-033 Without ILLEGAL_TRAP_EN, the ILLEGAL state SHALL NOT exist, an unknown op SHALL return to FETCH, and illegal SHALL be tied to 0.

Structure
REQ-034 The shared constants file SHALL hold the state encodings, opcode constants, imm_*_type codes and result_src/alu_src codes.
REQ-035 One sub-module, branch_cond, SHALL be used: a combinational funct3/flags-to-take evaluator.

Verification
REQ-036 The bench SHALL cover: op=0110011 (add) with mem_ready=1 -> FETCH,DECODE,EXEC_R,ALU_WB, reg_write=1 only in cycle 4.
REQ-037 The bench SHALL cover: op=0000011 (lw) with mem_ready low for 2 cycles in MEM_RD -> 7 cycles total, and reg_write=1 with result_src=1 once.
REQ-038 The bench SHALL cover: op=1100011, funct3=000, alu_zero=1 -> pc_write=1 in BRANCH; with alu_zero=0 -> pc_write=0.
REQ-039 The bench SHALL cover: rst=0 asserted mid-MEM_WR -> mem_write=0 before the next edge, and state FETCH after release.
REQ-040 The bench SHALL cover: op=0000000 with ILLEGAL_TRAP_EN defined -> illegal=1 held for 10 cycles; without the macro -> back in FETCH after 2 cycles.
REQ-041 The bench SHALL cover: op=0110111 (lui) -> imm_src=imm_U_type and result_src=2 in LUI, 3 cycles total.
